mem_port_arbiter: RTL

- Two-requester arbiter for one shared memory port, e.g. instruction fetch (port 0) and load/store (port 1) sharing a single memory.
- Drives the select line of the 32-bit 2:1 address/data mux in front of the memory and sequences one transaction at a time.
- Uses round-robin fairness and holds the grant stable until the memory acknowledges.
- Sits between the pipeline stage request logic and the memory interface.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter for two requesters sharing one memory port.
// Drives the 2:1 address/data mux select and sequences a single transaction at a
// time. The grant is held from the IDLE->BUSY edge until the memory acknowledges.
// Optional feature macro: ARB_TIMEOUT_EN aborts a transaction after TIMEOUT
// BUSY cycles without mem_ack_i and pulses timeout_o for one cycle.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic mem_ack_i,
    output logic select_o,
    output logic mem_req_o,
    output logic ack0_o,
    output logic ack1_o,
    output logic busy_o,
    output logic timeout_o
);

    // Catch an abort threshold the wait counter cannot represent.
    if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_timeout_range
        $error("mem_port_arbiter: TIMEOUT out of range for CNT_W");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   select_q, select_d;
    logic   mem_req_q, mem_req_d;
    logic   busy_q, busy_d;
    logic   last_q, last_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // State and grant registers; reset abandons any transaction without an ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            select_q  <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state: round-robin grant in IDLE, hold the grant in BUSY until ack (or abort).
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        mem_req_d = mem_req_q;
        busy_d    = busy_q;
        last_d    = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    // A tie goes to the port that was not served last.
                    select_d  = (req0_i && req1_i) ? ~last_q : req1_i;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    last_d    = select_q;
                    state_d   = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    // Abort: the requester keeps its req and competes again.
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    last_d    = select_q;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign select_o  = select_q;
    assign mem_req_o = mem_req_q;
    assign busy_o    = busy_q;

    // Completion strobes follow mem_ack_i in the same cycle, routed to the granted port.
    assign ack0_o = (state_q == BUSY) & mem_ack_i & ~select_q;
    assign ack1_o = (state_q == BUSY) & mem_ack_i &  select_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
